// File: rtl/pattern_sender.sv
// pattern_sender: valid/ready traffic source that emits framed packets of
// PKT_LEN beats. Packets rotate round-robin over NUM_CH channels. Each
// packet uses an incrementing or Galois-LFSR data pattern, chosen at its
// first beat. Valid is sticky: once raised, the beat holds with a stable
// payload until it is accepted.
//
// Ports:
//   clk          rising-edge clock for all logic
//   reset        synchronous, active-high reset
//   enable       permits launch of new beats
//   random_valid per-cycle launch request
//   mode         pattern select (0 = increment, 1 = LFSR), latched at packet start
//   ready_i      sink ready
//   valid_o      beat valid
//   data_o       beat payload (value of the current channel)
//   last_o       final beat of the packet
//   ch_o         channel of the current packet
//   pkt_cnt_o    completed-packet count, wraps at 2^16
module pattern_sender #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       PKT_LEN   = 16,
   parameter int unsigned       NUM_CH    = 4,
   parameter logic [DATA_W-1:0] START_VAL = DATA_W'(1),
   parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(8'hB8),
   // Derived channel index width; not meant to be overridden.
   parameter int unsigned       CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              random_valid,
   input  logic              mode,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o,
   output logic [CH_W-1:0]   ch_o,
   output logic [15:0]       pkt_cnt_o
);

   localparam int unsigned       BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
   localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

   logic [DATA_W-1:0] val_q [NUM_CH];
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              pmode_q, pmode_d;
   logic              valid_q, valid_d;
   logic [15:0]       pkt_cnt_q, pkt_cnt_d;

   logic [DATA_W-1:0] cur_val;
   logic [DATA_W-1:0] next_val;
   logic              handshake;
   logic              is_last;
   logic              launch_slot;
   logic              val_upd;

   assign cur_val     = val_q[ch_q];
   assign handshake   = valid_q & ready_i;
   assign is_last     = (beat_q == LAST_BEAT);
   // A new launch decision is taken only when no beat is pending or the
   // pending one is leaving this cycle; otherwise valid stays sticky.
   assign launch_slot = ~valid_q | handshake;

   // Pattern advance for the current channel, using the mode latched for
   // the packet in flight.
   always_comb begin
      next_val = cur_val + DATA_W'(1);
      if (pmode_q) begin
         if (cur_val == '0) begin
            // The all-zero state would lock the LFSR; kick it back to 1.
            next_val = DATA_W'(1);
         end else begin
            next_val = (cur_val >> 1) ^ (cur_val[0] ? LFSR_POLY : '0);
         end
      end
   end

   always_comb begin
      valid_d   = valid_q;
      beat_d    = beat_q;
      ch_d      = ch_q;
      pmode_d   = pmode_q;
      pkt_cnt_d = pkt_cnt_q;
      val_upd   = 1'b0;

      if (handshake) begin
         val_upd = 1'b1;
         if (is_last) begin
            beat_d    = '0;
            ch_d      = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
            pkt_cnt_d = pkt_cnt_q + 16'd1;
         end else begin
            beat_d = beat_q + BEAT_W'(1);
         end
      end

      if (launch_slot) begin
         valid_d = enable & random_valid;
         // beat_d already reflects this cycle's handshake, so a launch that
         // follows a last beat picks up the mode for the new packet.
         if (enable && random_valid && (beat_d == '0)) begin
            pmode_d = mode;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         beat_q    <= '0;
         ch_q      <= '0;
         pmode_q   <= 1'b0;
         pkt_cnt_q <= '0;
         for (int c = 0; c < int'(NUM_CH); c++) begin
            val_q[c] <= START_VAL;
         end
      end else begin
         valid_q   <= valid_d;
         beat_q    <= beat_d;
         ch_q      <= ch_d;
         pmode_q   <= pmode_d;
         pkt_cnt_q <= pkt_cnt_d;
         if (val_upd) begin
            val_q[ch_q] <= next_val;
         end
      end
   end

   assign valid_o   = valid_q;
   assign data_o    = cur_val;
   // Gated with valid so last reads 0 while idle and straight out of reset.
   assign last_o    = valid_q & is_last;
   assign ch_o      = ch_q;
   assign pkt_cnt_o = pkt_cnt_q;

endmodule
